x1_resp_fifo: RTL and testbench
===============================

X1_RESP_FIFO -- requirements
Module: x1_resp_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of FIFO entries; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have parameter W, default 35, meaning response word width; fixed at 35 by the x1 output bus.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_data, input, W bits: x1 response word, bit 34=a1 … bit 0=z1, in x1 declared output order.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the FIFO can accept a word.
REQ-008 SHALL have port out_data, output, W bits: head-of-FIFO word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-011 SHALL have port level, output, 5 bits: current occupancy, 0..DEPTH.
REQ-012 SHALL have port err_pair, output, 4 bits: sticky complementary-pair violation mask.
REQ-013 SHALL have port err_cnt, output, 8 bits: saturating count of violating words.
REQ-014 SHALL have port err_clr, input, 1 bit: single-cycle clear of err_pair and err_cnt.

Function
REQ-015 SHALL accept (push) a word when in_valid=1 and in_ready=1 in the same cycle.
REQ-016 SHALL drive in_ready = (level != DEPTH), combinationally from registered state only.
REQ-017 SHALL deliver (pop) a word when out_valid=1 and out_ready=1 in the same cycle.
REQ-018 SHALL drive out_valid = (level != 0) and out_data from the registered head entry (no combinational in→out path).
REQ-019 SHALL have a latency of exactly 1 cycle: a word pushed into an empty FIFO appears on out_data with out_valid=1 in the following cycle.
REQ-020 SHALL preserve word order and content bit-exact.
REQ-021 SHALL, on simultaneous push and pop with 0<level<DEPTH, perform both and leave level unchanged.
REQ-022 SHALL, when full, hold in_ready=0, so no push occurs even if a pop happens in the same cycle; in_ready rises the cycle after the pop.
REQ-023 SHALL, when empty, treat out_ready as don't-care with no state change.
REQ-024 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH; level is tracked separately.
REQ-025 SHALL, on each push, evaluate the pairs P0: bit27 == ~bit25 (d2/e2), P1: bit23 == ~bit24 (f2/g2), P2: bit17 == ~bit19 (i2/h2), P3: bit1 == ~bit2 (y1/x1); a failing pair k sets err_pair[k] in the next cycle.
REQ-026 SHALL increment err_cnt by 1 per pushed word with any failing pair, saturating at 255.
REQ-027 SHALL, when err_clr=1, zero err_pair and err_cnt in the next cycle; if a violating push occurs in the same cycle, the result is err_pair = that word's mask and err_cnt=1.
REQ-028 SHALL ignore words presented with in_valid=1 and in_ready=0 for checking purposes.

Reset
REQ-029 SHALL, with rst_n=0 at a clock edge, set level=0, both pointers=0, out_valid=0, in_ready=1, err_pair=0 and err_cnt=0; out_data is don't-care while out_valid=0.
REQ-030 SHALL discard all stored words on a reset mid-operation; pushes and pops in the reset cycle have no effect.
REQ-031 SHALL leave FIFO storage itself unreset.

Configuration
REQ-032 SHALL, with macro X1_PAIR_CHECK_EN defined, implement REQ-025..REQ-028.
REQ-033 SHALL, with X1_PAIR_CHECK_EN undefined, keep the err_pair, err_cnt and err_clr ports, tie err_pair=0 and err_cnt=0, ignore err_clr, and instantiate no checker logic; FIFO behaviour is identical.

Verification
REQ-034 SHALL cover the single-word case: after reset, push 35'h5_5555_5555 with out_ready=0 → next cycle out_valid=1, out_data=35'h5_5555_5555, level=1.
REQ-035 SHALL cover the full case: with out_ready=0, push 5 words with DEPTH=4 → in_ready=0 after the 4th push, the 5th is not accepted, level=4; then pop 4 → data in order and level=0.
REQ-036 SHALL cover streaming: continuous push with out_ready=1 for 20 words → throughput 1/cycle, pointer wrap, level constant at 1, no loss.
REQ-037 SHALL cover pair violations: push a word with bit27=bit25=1 and bit1=bit2=0 (other pairs consistent) → err_pair=4'b1001, err_cnt=1; then 300 such words → err_cnt=255.
REQ-038 SHALL cover clear versus violation: err_clr=1 in the same cycle as a P2-violating push → err_pair=4'b0100, err_cnt=1.
REQ-039 SHALL cover reset mid-operation: rst_n=0 for 1 cycle at level=3 → level=0, out_valid=0, in_ready=1, err outputs 0.

Source files
------------

// File: rtl/x1_resp_fifo.sv
// ---------------------------------------------------------------------------
// x1_resp_fifo
//
// Buffers x1 response words between the x1 output bus and a downstream
// consumer. Outputs come only from registers, so a word pushed into an
// empty FIFO shows up on out_data one cycle later.
//
// Optional feature: define X1_PAIR_CHECK_EN to enable the complementary-pair
// checker. Each accepted word is checked for four signal pairs that must be
// complements of each other. Without the macro, err_pair and err_cnt are tied
// to zero, err_clr is ignored, and no checker logic is built.
//
// Handshake rules: a transfer happens on a rising edge when valid and ready
// are both 1. Ready never depends on valid in the same cycle. A producer
// that has raised valid keeps its word on the bus until the transfer.
//
// Parameters
//   DEPTH     number of entries (2, 4, 8 or 16)
//   W         response word width (35)
// Ports
//   clk       clock; all state changes on its rising edge
//   rst_n     synchronous active-low reset
//   in_data   x1 response word (bit 34 = a1 ... bit 0 = z1)
//   in_valid  in_data is valid
//   in_ready  FIFO can accept a word (level != DEPTH)
//   out_data  head-of-FIFO word
//   out_valid out_data is valid (level != 0)
//   out_ready consumer accepts out_data
//   level     current occupancy, 0..DEPTH
//   err_pair  sticky complementary-pair violation mask
//   err_cnt   saturating count of violating words
//   err_clr   single-cycle clear of err_pair / err_cnt
// ---------------------------------------------------------------------------
module x1_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   level,
    output logic [3:0]   err_pair,
    output logic [7:0]   err_cnt,
    input  logic         err_clr
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [4:0] FULL_LVL = 5'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    level_q;
    logic          push;
    logic          pop;

    // Ready and valid depend only on the registered occupancy.
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = (level_q != 5'd0);
    assign out_data  = mem[rd_ptr];
    assign level     = level_q;

    assign push = in_valid  && in_ready;
    assign pop  = out_valid && out_ready;

    // The storage array has no reset. The write is gated with rst_n so that
    // a push in the reset cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + 5'd1;
                2'b01:   level_q <= level_q - 5'd1;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef X1_PAIR_CHECK_EN
    logic [3:0] pair_fail;

    // A pair fails when its two bits are equal instead of complementary.
    // The mask order is P3 (y1/x1), P2 (i2/h2), P1 (f2/g2), P0 (d2/e2).
    assign pair_fail = {in_data[1]  == in_data[2],
                        in_data[17] == in_data[19],
                        in_data[23] == in_data[24],
                        in_data[27] == in_data[25]};

    // When err_clr and a violating push happen in the same cycle, the
    // clear wins for the old history. The new word is still recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pair <= 4'd0;
            err_cnt  <= 8'd0;
        end else if (err_clr) begin
            err_pair <= push ? pair_fail : 4'd0;
            err_cnt  <= (push && (pair_fail != 4'd0)) ? 8'd1 : 8'd0;
        end else if (push && (pair_fail != 4'd0)) begin
            err_pair <= err_pair | pair_fail;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_err_clr;

    assign err_pair       = 4'd0;
    assign err_cnt        = 8'd0;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_x1_resp_fifo.sv
// ---------------------------------------------------------------------------
// tb_x1_resp_fifo
//
// A queue-based reference model is updated on every rising edge. On every
// falling edge, after reset has been seen, the DUT outputs are compared
// against it. Directed sections pin the model with literal values.
// Randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_x1_resp_fifo;

    localparam int DEPTH = 4;
    localparam int W     = 35;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   level;
    logic [3:0]   err_pair;
    logic [7:0]   err_cnt;
    logic         err_clr;

    always #5 clk = ~clk;

    x1_resp_fifo #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .err_pair  (err_pair),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    logic [3:0]   m_pair = 4'd0;
    int           m_cnt  = 0;
    bit           model_live = 1'b0;

    // Failing-pair mask: the pair's bits must be complements.
    function automatic logic [3:0] pair_mask(input logic [W-1:0] d);
        logic [3:0] m;
        m[0] = (d[27] !== ~d[25]);
        m[1] = (d[23] !== ~d[24]);
        m[2] = (d[17] !== ~d[19]);
        m[3] = (d[1]  !== ~d[2]);
        return m;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_pair     = 4'd0;
            m_cnt      = 0;
            model_live = 1'b1;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = in_valid && (exp_q.size() < DEPTH);
            do_pop  = out_ready && (exp_q.size() > 0);
`ifdef X1_PAIR_CHECK_EN
            begin
                logic [3:0] mk;
                mk = do_push ? pair_mask(in_data) : 4'd0;
                if (err_clr) begin
                    m_pair = mk;
                    m_cnt  = (mk != 0) ? 1 : 0;
                end else if (mk != 0) begin
                    m_pair = m_pair | mk;
                    m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
                end
            end
`endif
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(in_data);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_live) begin
            chk("level",     64'(level),     64'(exp_q.size()));
            chk("in_ready",  64'(in_ready),  64'(exp_q.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("out_data", 64'(out_data), 64'(exp_q[0]));
            chk("err_pair",  64'(err_pair),  64'(m_pair));
            chk("err_cnt",   64'(err_cnt),   64'(m_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    // Apply the inputs for one cycle. Returns at the next falling edge,
    // after the rising edge that consumed them.
    task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        err_clr   = clr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Words used by the directed sections.
    localparam logic [W-1:0] WORD_A  = 35'h5_5555_5555;
    // P0 and P3 violate, P1 and P2 are consistent.
    localparam logic [W-1:0] BAD_P03 = (35'd1 << 27) | (35'd1 << 25) | (35'd1 << 23) | (35'd1 << 17);
    // Only P2 violates.
    localparam logic [W-1:0] BAD_P2  = (35'd1 << 27) | (35'd1 << 23) | (35'd1 << 17) | (35'd1 << 19) | (35'd1 << 1);

    logic [W-1:0] words [5];
    logic [W-1:0] rnd;

    initial begin
        words[0] = 35'h1_2345_6789;
        words[1] = 35'h7_FFFF_0000;
        words[2] = 35'h0_0000_0001;
        words[3] = 35'h4_0000_0000;
        words[4] = 35'h3_CAFE_BEEF;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset values
        chk("rst_level",  64'(level),    64'd0);
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_iready", 64'(in_ready), 64'd1);
        chk("rst_epair",  64'(err_pair), 64'd0);
        chk("rst_ecnt",   64'(err_cnt),  64'd0);

        // Single word, one-cycle latency
        step(1'b1, WORD_A, 1'b0, 1'b0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data",  64'(out_data),  64'(WORD_A));
        chk("single_level", 64'(level),     64'd1);

        // Fill to full, then push a fifth word that must be refused
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
        chk("full_iready", 64'(in_ready), 64'd0);
        chk("full_level",  64'(level),    64'd4);
        step(1'b1, words[4], 1'b0, 1'b0);
        chk("full5_level", 64'(level), 64'd4);
        // Pop while full with a push offered: the push is blocked
        step(1'b1, words[4], 1'b1, 1'b0);
        chk("fullpop_level",  64'(level),    64'd3);
        chk("fullpop_iready", 64'(in_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk("drain_data", 64'(out_data), 64'(words[i]));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_level", 64'(level), 64'd0);
        // out_ready while empty changes nothing
        step(1'b0, '0, 1'b1, 1'b0);
        chk("empty_level", 64'(level), 64'd0);

        // Streaming 20 words at one per cycle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            rnd = W'({$urandom(), $urandom()});
            step(1'b1, rnd, 1'b1, 1'b0);
            chk("stream_level", 64'(level),    64'd1);
            chk("stream_data",  64'(out_data), 64'(rnd));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_end", 64'(level), 64'd0);

        // Pair violations
        do_reset();
        step(1'b1, BAD_P03, 1'b0, 1'b0);
`ifdef X1_PAIR_CHECK_EN
        chk("pair_mask", 64'(err_pair), 64'b1001);
        chk("pair_cnt1", 64'(err_cnt),  64'd1);
`else
        chk("pair_mask_off", 64'(err_pair), 64'd0);
        chk("pair_cnt_off",  64'(err_cnt),  64'd0);
`endif
        for (int i = 0; i < 300; i++) step(1'b1, BAD_P03, 1'b1, 1'b0);
`ifdef X1_PAIR_CHECK_EN
        chk("pair_sat", 64'(err_cnt), 64'd255);
`else
        chk("pair_sat_off", 64'(err_cnt), 64'd0);
`endif
        // Clear in the same cycle as a P2 violation
        step(1'b1, BAD_P2, 1'b1, 1'b1);
`ifdef X1_PAIR_CHECK_EN
        chk("clr_mask", 64'(err_pair), 64'b0100);
        chk("clr_cnt",  64'(err_cnt),  64'd1);
`else
        chk("clr_mask_off", 64'(err_pair), 64'd0);
`endif

        // Reset mid-operation at level 3, with a push and a pop offered
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, BAD_P03, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd3);
        rst_n = 1'b0;
        step(1'b1, words[0], 1'b1, 1'b0);
        rst_n = 1'b1;
        chk("midrst_level",  64'(level),     64'd0);
        chk("midrst_valid",  64'(out_valid), 64'd0);
        chk("midrst_iready", 64'(in_ready),  64'd1);
        chk("midrst_epair",  64'(err_pair),  64'd0);
        chk("midrst_ecnt",   64'(err_cnt),   64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic r;
            logic c;
            v = ($urandom_range(9, 0) < 7);
            r = (i % 400 < 200) ? ($urandom_range(9, 0) < 3) : ($urandom_range(9, 0) < 8);
            c = ($urandom_range(19, 0) == 0);
            rnd = W'({$urandom(), $urandom()});
            rst_n = ($urandom_range(499, 0) != 0);
            step(v, rnd, r, c);
            rst_n = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
